dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined ARM core: the slave end of the Memory-stage load/store interface.
- Accepts one word load/store per request from the M stage and inserts a parameterised number of wait states.
- Drives a busy/stall line back to the hazard logic so the pipeline holds while an access is in flight.
- Returns read data and a one-cycle response strobe; flags misaligned or out-of-range addresses.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, 4..4096)
WAIT_CYCLES, 2, wait states inserted between accept and response (0..15)
ADDR_BASE, 32'h0000_0000, byte address of word 0 (word aligned)

Ports:
CLK_50  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_req  input  1  M stage has a load or store this cycle (MemWriteM or MemtoRegM)
mem_we  input  1  1 = store, 0 = load; sampled with mem_req
mem_addr  input  32  byte address (ALUResultM)
mem_wdata  input  32  store data (WriteDataM)
mem_rdata  output  32  load data, valid when resp_valid=1
resp_valid  output  1  one-cycle completion strobe
mem_busy  output  1  stall request to the hazard unit (holds F/D/E/M)
addr_err  output  1  with resp_valid: access was misaligned or out of range

Behaviour:
- Clock and reset: one clock CLK_50; reset asynchronous, active-high.
- Reset values: state=IDLE, wait counter=0, mem_rdata=0, resp_valid=0, addr_err=0, latched request cleared.
- Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE with mem_req=1: latch addr/we/wdata and load the counter with WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else RESP.
- IDLE with mem_req=0: stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter is 1, the next state is RESP.
- Access is performed on the edge entering RESP. Stores write the array; loads register the word into mem_rdata.
- RESP: resp_valid=1 and addr_err valid for exactly one cycle; next state is IDLE unconditionally.
- mem_req is ignored in RESP. The pipeline advances on this edge, so the next instruction presents next cycle.
- mem_busy (combinational) = (state==IDLE & mem_req) | (state==WAIT). It is 0 in RESP.
- Busy length per access = WAIT_CYCLES+1. Response arrives WAIT_CYCLES+1 cycles after accept.
- Back-to-back requests: RESP -> IDLE -> accept. There is one idle cycle minimum between responses.
- Inputs are sampled only at accept; changes to mem_addr/mem_wdata during WAIT have no effect.
- Address rules:
  - offset = mem_addr - ADDR_BASE (32-bit wrap).
  - word index = offset[log2(DEPTH_WORDS)+1:2].
  - Error if offset[1:0]!=0 or offset >= DEPTH_WORDS*4.
- On error: store suppressed (array unchanged), mem_rdata=0, addr_err=1 in RESP.
- mem_rdata holds its last value outside RESP. It is cleared only by reset or an errored load.
- Boundary addresses:
  - Index DEPTH_WORDS-1 is legal.
  - ADDR_BASE+DEPTH_WORDS*4 errors.
  - An address below ADDR_BASE wraps to a large offset and errors.
- Reset mid-operation: FSM returns to IDLE immediately. A pending store in WAIT is discarded and never written. mem_busy drops asynchronously with reset.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP};
  - localparam WORD_BYTES=4;
  - function dmem_addr_ok(offset, depth) returning the legality bit.
- Sub-module dmem_array:
  - DEPTH_WORDS x 32 storage, synchronous write, registered read; no reset.
  - Instantiated once. FSM, counter, address checks and outputs stay in dmem_responder.

Test Plan:
- Reset then store 32'hDEAD_BEEF at 0x10 (WAIT_CYCLES=2) -> mem_busy high 3 cycles, resp_valid pulses on cycle 3, addr_err=0. Later load from 0x10 -> mem_rdata=32'hDEAD_BEEF with resp_valid.
- WAIT_CYCLES=0, load at 0x0 after storing 32'h1234_5678 -> mem_busy high exactly 1 cycle, resp_valid next cycle, mem_rdata=32'h1234_5678.
- Back-to-back loads from 0x4 and 0x8 held on mem_req -> two resp_valid pulses with one IDLE cycle between; mem_busy=0 in each RESP cycle.
- Store to 0x102 (misaligned) and to 0x100 with DEPTH_WORDS=64 (out of range) -> each gives addr_err=1 with resp_valid. Readback of words 0 and 63 shows them unchanged; errored load returns 0.
- Store 32'hAAAA_5555 to 0x20, assert reset during WAIT -> all outputs 0 immediately, FSM IDLE. Subsequent load from 0x20 returns the prior value, not 32'hAAAA_5555.
- Change mem_addr/mem_wdata during WAIT (accepted 0x30 / 32'h1, then 0x34 / 32'h2) -> only word 0x30=32'h1 written; word 0x34 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address check lives here so the FSM and any future checker agree on it.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic dmem_addr_ok(input logic [31:0] offset, input int unsigned depth);
    logic [31:0] limit;
    limit = depth * WORD_BYTES;
    return (offset[1:0] == 2'b00) && (offset < limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store bus between the pipeline (master) and the data memory (slave).
// The master drives the request and samples the busy, response and error lines.
interface dmem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        mem_busy;
  logic        addr_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, resp_valid, mem_busy, addr_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, resp_valid, mem_busy, addr_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, registered read that holds when rd_en is low.
// No reset on contents or read register; the responder masks rd_data until a good load.
module dmem_array #(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_data;
    if (rd_en) rd_data <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the M-stage load/store bus: accept, wait WAIT_CYCLES, then one RESP cycle.
// mem_busy stalls the pipeline from accept until the response; mem_req is ignored in RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic             CLK_50,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic [31:0] off_q, wdata_q;
  logic        we_q;
  logic        err_q;
  logic        rdata_zero;

  logic [31:0] acc_off, acc_wdata;
  logic        acc_we, acc_ok;
  logic        accept, do_access;
  logic [31:0] arr_rdata;

  assign accept = (state == IDLE) && bus.mem_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          cnt_nxt   = WAIT_INIT;
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live inputs.
  assign acc_off   = (state == IDLE) ? (bus.mem_addr - ADDR_BASE) : off_q;
  assign acc_we    = (state == IDLE) ? bus.mem_we : we_q;
  assign acc_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;
  assign acc_ok    = dmem_addr_ok(acc_off, DEPTH_WORDS);
  assign do_access = (state_nxt == RESP) && !reset;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (CLK_50),
    .wr_en   (do_access && acc_we && acc_ok),
    .rd_en   (do_access && !acc_we && acc_ok),
    .idx     (acc_off[AW+1:2]),
    .wr_data (acc_wdata),
    .rd_data (arr_rdata)
  );

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      off_q      <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        off_q   <= bus.mem_addr - ADDR_BASE;
        we_q    <= bus.mem_we;
        wdata_q <= bus.mem_wdata;
      end
      if (do_access) begin
        err_q <= !acc_ok;
        // Only loads touch the read data; stores leave the last load result visible.
        if (!acc_we) rdata_zero <= !acc_ok;
      end
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.addr_err   = (state == RESP) && err_q;
  assign bus.mem_rdata  = rdata_zero ? 32'd0 : arr_rdata;
  assign bus.mem_busy   = !reset && (accept || (state == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover 2, 0 and 1 wait states
// plus a non-zero base address; all expected values are hand-computed constants.
module tb_dmem_responder;

  logic clk;
  logic reset;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();
  dmem_responder_if ifc ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000))
    dut_a (.CLK_50(clk), .reset(reset), .bus(ifa));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_0000))
    dut_b (.CLK_50(clk), .reset(reset), .bus(ifb));
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1), .ADDR_BASE(32'h0000_0100))
    dut_c (.CLK_50(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        s_busy, s_rv, s_err;
  logic [31:0] s_rd;
  int          a_busy;
  logic        a_ok;

  logic        bb_rv   [10];
  logic        bb_busy [10];
  logic [31:0] bb_rd   [10];
  int          bb_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    case (sel)
      0: begin ifa.mem_req = req; ifa.mem_we = we; ifa.mem_addr = addr; ifa.mem_wdata = wdata; end
      1: begin ifb.mem_req = req; ifb.mem_we = we; ifb.mem_addr = addr; ifb.mem_wdata = wdata; end
      default: begin ifc.mem_req = req; ifc.mem_we = we; ifc.mem_addr = addr; ifc.mem_wdata = wdata; end
    endcase
  endtask

  task automatic sample(input int sel);
    case (sel)
      0: begin s_busy = ifa.mem_busy; s_rv = ifa.resp_valid; s_err = ifa.addr_err; s_rd = ifa.mem_rdata; end
      1: begin s_busy = ifb.mem_busy; s_rv = ifb.resp_valid; s_err = ifb.addr_err; s_rd = ifb.mem_rdata; end
      default: begin s_busy = ifc.mem_busy; s_rv = ifc.resp_valid; s_err = ifc.addr_err; s_rd = ifc.mem_rdata; end
    endcase
  endtask

  // One request; returns at the RESP cycle with s_* holding the response outputs.
  // With chg set, addr2/wdata2 are presented during the wait states.
  task automatic access(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chg,
                        input logic [31:0] addr2, input logic [31:0] wdata2);
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata);
    a_busy = 0;
    a_ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      sample(sel);
      if (s_rv) begin
        a_ok = 1'b1;
        break;
      end
      if (s_busy) a_busy++;
      @(negedge clk);
      if (chg) drive(sel, 1'b0, we, addr2, wdata2);
      else     drive(sel, 1'b0, we, addr, wdata);
    end
    chk("resp_seen", 32'(a_ok), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    sample(0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_rv",   32'(s_rv),   32'd0);
    chk("rst_err",  32'(s_err),  32'd0);
    chk("rst_rd",   s_rd,        32'd0);
    reset = 1'b0;

    // ---- instance A: 2 wait states ----
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
    chk("st10_busy_len", 32'(a_busy), 32'd3);
    chk("st10_err",      32'(s_err),  32'd0);
    chk("st10_busy_resp", 32'(s_busy), 32'd0);

    access(0, 1'b1, 32'h00, 32'h0000_A000, 1'b0, 32'd0, 32'd0);
    access(0, 1'b1, 32'hFC, 32'h0000_A0FC, 1'b0, 32'd0, 32'd0);
    chk("st_last_word_err", 32'(s_err), 32'd0);
    access(0, 1'b1, 32'h04, 32'h0000_0404, 1'b0, 32'd0, 32'd0);
    access(0, 1'b1, 32'h08, 32'h0000_0808, 1'b0, 32'd0, 32'd0);
    access(0, 1'b1, 32'h20, 32'h1111_2222, 1'b0, 32'd0, 32'd0);
    access(0, 1'b1, 32'h34, 32'h5A5A_0034, 1'b0, 32'd0, 32'd0);

    access(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld10_data", s_rd, 32'hDEAD_BEEF);
    chk("ld10_err",  32'(s_err), 32'd0);

    // back-to-back loads with mem_req held high
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h4, 32'd0);
    bb_pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      sample(0);
      bb_rv[c]   = s_rv;
      bb_busy[c] = s_busy;
      bb_rd[c]   = s_rd;
      if (s_rv) bb_pulses++;
      if (s_rv && bb_pulses == 1) drive(0, 1'b1, 1'b0, 32'h8, 32'd0);
      else if (s_rv)              drive(0, 1'b0, 1'b0, 32'h8, 32'd0);
      @(negedge clk);
    end
    chk("bb_pulses",     32'(bb_pulses),  32'd2);
    chk("bb_rv1",        32'(bb_rv[3]),   32'd1);
    chk("bb_busy_resp1", 32'(bb_busy[3]), 32'd0);
    chk("bb_rd1",        bb_rd[3],        32'h0000_0404);
    chk("bb_idle_rv",    32'(bb_rv[4]),   32'd0);
    chk("bb_idle_busy",  32'(bb_busy[4]), 32'd1);
    chk("bb_rv2",        32'(bb_rv[7]),   32'd1);
    chk("bb_busy_resp2", 32'(bb_busy[7]), 32'd0);
    chk("bb_rd2",        bb_rd[7],        32'h0000_0808);

    // address errors: misaligned and one past the end both alias word 0
    access(0, 1'b1, 32'h102, 32'hFFFF_0102, 1'b0, 32'd0, 32'd0);
    chk("st_misalign_err", 32'(s_err), 32'd1);
    access(0, 1'b1, 32'h100, 32'hFFFF_0100, 1'b0, 32'd0, 32'd0);
    chk("st_oor_err", 32'(s_err), 32'd1);
    access(0, 1'b0, 32'h00, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld_word0", s_rd, 32'h0000_A000);
    access(0, 1'b0, 32'hFC, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld_word63", s_rd, 32'h0000_A0FC);
    chk("ld_word63_err", 32'(s_err), 32'd0);
    @(negedge clk);
    #1;
    sample(0);
    chk("rd_hold_idle", s_rd, 32'h0000_A0FC);
    chk("rv_idle", 32'(s_rv), 32'd0);
    access(0, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld_oor_err", 32'(s_err), 32'd1);
    chk("ld_oor_rd",  s_rd, 32'd0);

    // reset while a store sits in WAIT
    access(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld10_again", s_rd, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAA_5555);
    #1;
    sample(0);
    chk("wait_busy", 32'(s_busy), 32'd1);
    reset = 1'b1;
    #1;
    sample(0);
    chk("midrst_busy", 32'(s_busy), 32'd0);
    chk("midrst_rv",   32'(s_rv),   32'd0);
    chk("midrst_err",  32'(s_err),  32'd0);
    chk("midrst_rd",   s_rd,        32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    sample(0);
    chk("post_rst_rv",   32'(s_rv),   32'd0);
    chk("post_rst_busy", 32'(s_busy), 32'd0);
    access(0, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld20_prior", s_rd, 32'h1111_2222);

    // inputs changed during WAIT must not affect the accepted store
    access(0, 1'b1, 32'h30, 32'h0000_0001, 1'b1, 32'h34, 32'h0000_0002);
    chk("chg_err", 32'(s_err), 32'd0);
    access(0, 1'b0, 32'h30, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld30", s_rd, 32'h0000_0001);
    access(0, 1'b0, 32'h34, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("ld34", s_rd, 32'h5A5A_0034);

    // ---- instance B: zero wait states ----
    access(1, 1'b1, 32'h0, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
    chk("b_st_busy_len", 32'(a_busy), 32'd1);
    access(1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("b_ld_busy_len", 32'(a_busy), 32'd1);
    chk("b_ld_rd", s_rd, 32'h1234_5678);
    chk("b_ld_busy_resp", 32'(s_busy), 32'd0);

    // ---- instance C: base 0x100, 16 words, 1 wait state ----
    access(2, 1'b1, 32'h13C, 32'hCAFE_F00D, 1'b0, 32'd0, 32'd0);
    chk("c_st_busy_len", 32'(a_busy), 32'd2);
    chk("c_st_err", 32'(s_err), 32'd0);
    access(2, 1'b0, 32'h13C, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("c_ld_rd", s_rd, 32'hCAFE_F00D);
    access(2, 1'b0, 32'hFC, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("c_below_base_err", 32'(s_err), 32'd1);
    chk("c_below_base_rd",  s_rd, 32'd0);
    access(2, 1'b0, 32'h140, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("c_past_end_err", 32'(s_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
